// File: rtl/cva6_tlb_pkg.sv
// Shared types, constants and helpers for the parametrised Sv32 TLB with tree pseudo-LRU replacement.
package cva6_tlb_pkg;

  localparam int PTE_G_BIT = 5;

  // Entries store the ASID zero-extended to this width; ASID_WIDTH must not exceed it.
  localparam int MAX_ASID_WIDTH = 16;

  // Flush mode encoding is {use_asid, use_vaddr}.
  typedef enum logic [1:0] {
    FLUSH_ALL        = 2'b00,
    FLUSH_VADDR      = 2'b01,
    FLUSH_ASID       = 2'b10,
    FLUSH_ASID_VADDR = 2'b11
  } flush_mode_e;

  typedef struct packed {
    logic [9:0]                vpn1;
    logic [9:0]                vpn0;
    logic [MAX_ASID_WIDTH-1:0] asid;
    logic                      is_4M;
    logic [31:0]               content;
    logic                      valid;
  } tlb_entry_t;

  // A superpage entry ignores vpn0, both for lookup and for address-qualified flushes.
  function automatic logic vpn_match(input tlb_entry_t e, input logic [9:0] vpn1,
                                     input logic [9:0] vpn0);
    return (e.vpn1 == vpn1) && (e.is_4M || (e.vpn0 == vpn0));
  endfunction

endpackage

// File: rtl/cva6_tlb_plru_tree.sv
// Tree pseudo-LRU state for the TLB: one bit per internal node, heap-ordered (children of n at 2n+1, 2n+2).
module cva6_tlb_plru_tree
  import cva6_tlb_pkg::*;
#(
  parameter int ENTRIES = 8,
  localparam int IDX_W = $clog2(ENTRIES)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             touch_valid,
  input  logic [IDX_W-1:0] touch_idx,
  output logic [IDX_W-1:0] victim_idx
);

  localparam int LEVELS = IDX_W;

  logic [ENTRIES-2:0] tree_q;
  logic [ENTRIES-2:0] tree_d;

  // A node bit of 0 sends the victim left; touching an entry points every node on its path away from it.
  always_comb begin
    int node;
    tree_d = tree_q;
    node   = 0;
    if (touch_valid) begin
      for (int l = 0; l < LEVELS; l++) begin
        node         = (1 << l) - 1 + int'(touch_idx >> (LEVELS - l));
        tree_d[node] = ~touch_idx[LEVELS-1-l];
      end
    end
  end

  always_comb begin
    int node;
    victim_idx = '0;
    node       = 0;
    for (int l = 0; l < LEVELS; l++) begin
      victim_idx[LEVELS-1-l] = tree_q[node];
      node                   = 2 * node + 1 + int'(tree_q[node]);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tree_q <= '0;
    end else begin
      tree_q <= tree_d;
    end
  end

endmodule

// File: rtl/cva6_tlb_sv32_plru.sv
// Sv32 TLB with configurable depth/ASID width, global pages, selective flush and a registered lookup.
module cva6_tlb_sv32_plru
  import cva6_tlb_pkg::*;
#(
  parameter int TLB_ENTRIES = 8,
  parameter int ASID_WIDTH  = 9
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  flush_use_asid_i,
  input  logic                  flush_use_vaddr_i,
  input  logic [ASID_WIDTH-1:0] asid_to_be_flushed_i,
  input  logic [31:0]           vaddr_to_be_flushed_i,
  input  logic                  update_valid_i,
  input  logic                  update_is_4M_i,
  input  logic [19:0]           update_vpn_i,
  input  logic [ASID_WIDTH-1:0] update_asid_i,
  input  logic [31:0]           update_content_i,
  input  logic                  lu_access_i,
  input  logic [ASID_WIDTH-1:0] lu_asid_i,
  input  logic [31:0]           lu_vaddr_i,
  output logic                  lu_hit_o,
  output logic                  lu_is_4M_o,
  output logic [31:0]           lu_content_o
);

  localparam int IDX_W = $clog2(TLB_ENTRIES);

  tlb_entry_t tlb_q [TLB_ENTRIES];
  tlb_entry_t tlb_d [TLB_ENTRIES];

  logic [TLB_ENTRIES-1:0]    lu_match;
  logic [TLB_ENTRIES-1:0]    upd_exact;
  logic [TLB_ENTRIES-1:0]    flush_hit;
  logic [TLB_ENTRIES-1:0]    valid_vec;
  logic [IDX_W-1:0]          lu_idx;
  logic [IDX_W-1:0]          exact_idx;
  logic [IDX_W-1:0]          free_idx;
  logic [IDX_W-1:0]          victim_idx;
  logic [IDX_W-1:0]          upd_idx;
  logic [IDX_W-1:0]          touch_idx;
  logic                      update_en;
  logic                      lu_valid;
  logic                      touch_valid;
  logic [MAX_ASID_WIDTH-1:0] lu_asid;
  logic [MAX_ASID_WIDTH-1:0] upd_asid;
  logic [MAX_ASID_WIDTH-1:0] fl_asid;
  flush_mode_e               flush_mode;

  logic        lu_hit_d, lu_hit_q;
  logic        lu_is_4M_d, lu_is_4M_q;
  logic [31:0] lu_content_d, lu_content_q;

  // Page-offset bits play no part in translation.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{lu_vaddr_i[11:0], vaddr_to_be_flushed_i[11:0]};

  assign lu_asid    = MAX_ASID_WIDTH'(lu_asid_i);
  assign upd_asid   = MAX_ASID_WIDTH'(update_asid_i);
  assign fl_asid    = MAX_ASID_WIDTH'(asid_to_be_flushed_i);
  assign flush_mode = flush_mode_e'({flush_use_asid_i, flush_use_vaddr_i});
  assign update_en  = update_valid_i && !flush_i;

  always_comb begin
    lu_match  = '0;
    upd_exact = '0;
    flush_hit = '0;
    valid_vec = '0;
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      valid_vec[i] = tlb_q[i].valid;
      lu_match[i]  = tlb_q[i].valid
                  && vpn_match(tlb_q[i], lu_vaddr_i[31:22], lu_vaddr_i[21:12])
                  && ((tlb_q[i].asid == lu_asid) || tlb_q[i].content[PTE_G_BIT]);
      upd_exact[i] = tlb_q[i].valid
                  && (tlb_q[i].vpn1 == update_vpn_i[19:10])
                  && (tlb_q[i].vpn0 == update_vpn_i[9:0])
                  && (tlb_q[i].asid == upd_asid)
                  && (tlb_q[i].is_4M == update_is_4M_i);
      // Global entries survive ASID-qualified flushes but not a pure address flush.
      case (flush_mode)
        FLUSH_ALL:   flush_hit[i] = 1'b1;
        FLUSH_ASID:  flush_hit[i] = !tlb_q[i].content[PTE_G_BIT] && (tlb_q[i].asid == fl_asid);
        FLUSH_VADDR: flush_hit[i] = vpn_match(tlb_q[i], vaddr_to_be_flushed_i[31:22],
                                              vaddr_to_be_flushed_i[21:12]);
        FLUSH_ASID_VADDR:
          flush_hit[i] = !tlb_q[i].content[PTE_G_BIT] && (tlb_q[i].asid == fl_asid)
                      && vpn_match(tlb_q[i], vaddr_to_be_flushed_i[31:22],
                                   vaddr_to_be_flushed_i[21:12]);
        default:     flush_hit[i] = 1'b1;
      endcase
    end
  end

  // Scanning downwards leaves the lowest matching index in each encoder.
  always_comb begin
    lu_idx    = '0;
    exact_idx = '0;
    free_idx  = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (lu_match[i])   lu_idx    = IDX_W'(i);
      if (upd_exact[i])  exact_idx = IDX_W'(i);
      if (!valid_vec[i]) free_idx  = IDX_W'(i);
    end
  end

  always_comb begin
    upd_idx = victim_idx;
    if (|upd_exact) begin
      upd_idx = exact_idx;
    end else if (!(&valid_vec)) begin
      upd_idx = free_idx;
    end
  end

  always_comb begin
    tlb_d = tlb_q;
    if (flush_i) begin
      for (int i = 0; i < TLB_ENTRIES; i++) begin
        if (flush_hit[i]) tlb_d[i].valid = 1'b0;
      end
    end else if (update_en) begin
      tlb_d[upd_idx] = '{vpn1:    update_vpn_i[19:10],
                         vpn0:    update_vpn_i[9:0],
                         asid:    upd_asid,
                         is_4M:   update_is_4M_i,
                         content: update_content_i,
                         valid:   1'b1};
    end
  end

  // A lookup racing a flush is reported as a miss and does not age the PLRU.
  always_comb begin
    lu_valid     = lu_access_i && !flush_i && (|lu_match);
    lu_hit_d     = lu_valid;
    lu_is_4M_d   = lu_valid && tlb_q[lu_idx].is_4M;
    lu_content_d = lu_valid ? tlb_q[lu_idx].content : '0;
  end

  // The tree takes one touch per cycle; a simultaneous write is the more recent use.
  assign touch_valid = update_en || lu_valid;
  assign touch_idx   = update_en ? upd_idx : lu_idx;

  cva6_tlb_plru_tree #(
    .ENTRIES (TLB_ENTRIES)
  ) u_plru (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .touch_valid (touch_valid),
    .touch_idx   (touch_idx),
    .victim_idx  (victim_idx)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < TLB_ENTRIES; i++) begin
        tlb_q[i] <= '0;
      end
      lu_hit_q     <= 1'b0;
      lu_is_4M_q   <= 1'b0;
      lu_content_q <= '0;
    end else begin
      tlb_q        <= tlb_d;
      lu_hit_q     <= lu_hit_d;
      lu_is_4M_q   <= lu_is_4M_d;
      lu_content_q <= lu_content_d;
    end
  end

  assign lu_hit_o     = lu_hit_q;
  assign lu_is_4M_o   = lu_is_4M_q;
  assign lu_content_o = lu_content_q;

endmodule

// File: tb/tb_cva6_tlb_sv32_plru.sv
// Table-driven bench for cva6_tlb_sv32_plru with four entries and 9-bit ASIDs.
module tb_cva6_tlb_sv32_plru;

  localparam int ENTRIES = 4;
  localparam int AW      = 9;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          flush_i;
  logic          flush_use_asid_i;
  logic          flush_use_vaddr_i;
  logic [AW-1:0] asid_to_be_flushed_i;
  logic [31:0]   vaddr_to_be_flushed_i;
  logic          update_valid_i;
  logic          update_is_4M_i;
  logic [19:0]   update_vpn_i;
  logic [AW-1:0] update_asid_i;
  logic [31:0]   update_content_i;
  logic          lu_access_i;
  logic [AW-1:0] lu_asid_i;
  logic [31:0]   lu_vaddr_i;
  logic          lu_hit_o;
  logic          lu_is_4M_o;
  logic [31:0]   lu_content_o;

  always #5 clk_i = ~clk_i;

  cva6_tlb_sv32_plru #(
    .TLB_ENTRIES (ENTRIES),
    .ASID_WIDTH  (AW)
  ) dut (
    .clk_i                 (clk_i),
    .rst_i                 (rst_i),
    .flush_i               (flush_i),
    .flush_use_asid_i      (flush_use_asid_i),
    .flush_use_vaddr_i     (flush_use_vaddr_i),
    .asid_to_be_flushed_i  (asid_to_be_flushed_i),
    .vaddr_to_be_flushed_i (vaddr_to_be_flushed_i),
    .update_valid_i        (update_valid_i),
    .update_is_4M_i        (update_is_4M_i),
    .update_vpn_i          (update_vpn_i),
    .update_asid_i         (update_asid_i),
    .update_content_i      (update_content_i),
    .lu_access_i           (lu_access_i),
    .lu_asid_i             (lu_asid_i),
    .lu_vaddr_i            (lu_vaddr_i),
    .lu_hit_o              (lu_hit_o),
    .lu_is_4M_o            (lu_is_4M_o),
    .lu_content_o          (lu_content_o)
  );

  // One record drives one clock cycle; the expectation is the registered response to that cycle.
  typedef struct {
    string         name;
    logic          rst;
    logic          upd;
    logic          upd_4m;
    logic [19:0]   upd_vpn;
    logic [AW-1:0] upd_asid;
    logic [31:0]   upd_content;
    logic          lu;
    logic [AW-1:0] lu_asid;
    logic [31:0]   lu_vaddr;
    logic          fl;
    logic [1:0]    fl_mode;
    logic [AW-1:0] fl_asid;
    logic [31:0]   fl_vaddr;
    logic          exp_hit;
    logic          exp_4m;
    logic [31:0]   exp_content;
  } vec_t;

  vec_t vecs[$];
  int   testsRun    = 0;
  int   testsFailed = 0;

  function automatic vec_t blank(input string name);
    vec_t v;
    v.name        = name;
    v.rst         = 1'b0;
    v.upd         = 1'b0;
    v.upd_4m      = 1'b0;
    v.upd_vpn     = '0;
    v.upd_asid    = '0;
    v.upd_content = '0;
    v.lu          = 1'b0;
    v.lu_asid     = '0;
    v.lu_vaddr    = '0;
    v.fl          = 1'b0;
    v.fl_mode     = 2'b00;
    v.fl_asid     = '0;
    v.fl_vaddr    = '0;
    v.exp_hit     = 1'b0;
    v.exp_4m      = 1'b0;
    v.exp_content = '0;
    return v;
  endfunction

  function automatic vec_t upd(input string name, input logic [19:0] vpn, input logic [AW-1:0] asid,
                               input logic [31:0] content, input logic is4m);
    vec_t v;
    v             = blank(name);
    v.upd         = 1'b1;
    v.upd_vpn     = vpn;
    v.upd_asid    = asid;
    v.upd_content = content;
    v.upd_4m      = is4m;
    return v;
  endfunction

  function automatic vec_t lu(input string name, input logic [AW-1:0] asid, input logic [31:0] vaddr,
                              input logic hit, input logic is4m, input logic [31:0] content);
    vec_t v;
    v             = blank(name);
    v.lu          = 1'b1;
    v.lu_asid     = asid;
    v.lu_vaddr    = vaddr;
    v.exp_hit     = hit;
    v.exp_4m      = is4m;
    v.exp_content = content;
    return v;
  endfunction

  function automatic vec_t fl(input string name, input logic [1:0] mode, input logic [AW-1:0] asid,
                              input logic [31:0] vaddr);
    vec_t v;
    v          = blank(name);
    v.fl       = 1'b1;
    v.fl_mode  = mode;
    v.fl_asid  = asid;
    v.fl_vaddr = vaddr;
    return v;
  endfunction

  task automatic idleInputs();
    flush_i               = 1'b0;
    flush_use_asid_i      = 1'b0;
    flush_use_vaddr_i     = 1'b0;
    asid_to_be_flushed_i  = '0;
    vaddr_to_be_flushed_i = '0;
    update_valid_i        = 1'b0;
    update_is_4M_i        = 1'b0;
    update_vpn_i          = '0;
    update_asid_i         = '0;
    update_content_i      = '0;
    lu_access_i           = 1'b0;
    lu_asid_i             = '0;
    lu_vaddr_i            = '0;
  endtask

  task automatic checkOutput(input string name, input logic eh, input logic e4, input logic [31:0] ec);
    testsRun++;
    if (lu_hit_o !== eh) begin
      testsFailed++;
      $display("[TB] FAIL %s hit: got %b want %b", name, lu_hit_o, eh);
    end
    testsRun++;
    if (lu_is_4M_o !== e4) begin
      testsFailed++;
      $display("[TB] FAIL %s is_4M: got %b want %b", name, lu_is_4M_o, e4);
    end
    testsRun++;
    if (lu_content_o !== ec) begin
      testsFailed++;
      $display("[TB] FAIL %s content: got %h want %h", name, lu_content_o, ec);
    end
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
  task automatic applyStimulus(input vec_t v);
    if (v.rst) begin
      rst_i = 1'b1;
      #2;
      rst_i = 1'b0;
    end
    update_valid_i        = v.upd;
    update_is_4M_i        = v.upd_4m;
    update_vpn_i          = v.upd_vpn;
    update_asid_i         = v.upd_asid;
    update_content_i      = v.upd_content;
    lu_access_i           = v.lu;
    lu_asid_i             = v.lu_asid;
    lu_vaddr_i            = v.lu_vaddr;
    flush_i               = v.fl;
    flush_use_asid_i      = v.fl_mode[1];
    flush_use_vaddr_i     = v.fl_mode[0];
    asid_to_be_flushed_i  = v.fl_asid;
    vaddr_to_be_flushed_i = v.fl_vaddr;
    @(posedge clk_i);
    #1;
    idleInputs();
  endtask

  initial begin
    vec_t v;

    // Basic 4 KiB and 4 MiB translation.
    vecs.push_back(lu("reset_lookup", 9'd1, 32'h1234_5000, 1'b0, 1'b0, 32'h0));
    vecs.push_back(upd("upd_12345", 20'h12345, 9'd1, 32'h0ABC_D0CF, 1'b0));
    vecs.push_back(lu("hit_12345", 9'd1, 32'h1234_5000, 1'b1, 1'b0, 32'h0ABC_D0CF));
    vecs.push_back(lu("asid2_miss", 9'd2, 32'h1234_5000, 1'b0, 1'b0, 32'h0));
    vecs.push_back(upd("upd_4m", 20'h3FC00, 9'd1, 32'h0FF0_00CF, 1'b1));
    vecs.push_back(lu("hit_4m", 9'd1, 32'h3FCA_B000, 1'b1, 1'b1, 32'h0FF0_00CF));

    // PLRU replacement: fill, touch entries 0 and 2, then entry 1 is the victim.
    v = upd("fill1", 20'h00001, 9'd1, 32'h0000_10CF, 1'b0);
    v.rst = 1'b1;
    vecs.push_back(v);
    vecs.push_back(upd("fill2", 20'h00002, 9'd1, 32'h0000_20CF, 1'b0));
    vecs.push_back(upd("fill3", 20'h00003, 9'd1, 32'h0000_30CF, 1'b0));
    vecs.push_back(upd("fill4", 20'h00004, 9'd1, 32'h0000_40CF, 1'b0));
    vecs.push_back(lu("touch1", 9'd1, 32'h0000_1000, 1'b1, 1'b0, 32'h0000_10CF));
    vecs.push_back(lu("touch3", 9'd1, 32'h0000_3000, 1'b1, 1'b0, 32'h0000_30CF));
    vecs.push_back(upd("replace5", 20'h00005, 9'd1, 32'h0000_50CF, 1'b0));
    vecs.push_back(lu("evicted2", 9'd1, 32'h0000_2000, 1'b0, 1'b0, 32'h0));
    vecs.push_back(lu("kept1", 9'd1, 32'h0000_1000, 1'b1, 1'b0, 32'h0000_10CF));
    vecs.push_back(lu("kept3", 9'd1, 32'h0000_3000, 1'b1, 1'b0, 32'h0000_30CF));
    vecs.push_back(lu("kept4", 9'd1, 32'h0000_4000, 1'b1, 1'b0, 32'h0000_40CF));
    vecs.push_back(lu("new5", 9'd1, 32'h0000_5000, 1'b1, 1'b0, 32'h0000_50CF));

    // Selective flushes and global pages.
    v = upd("updA", 20'h00010, 9'd1, 32'h0001_00CF, 1'b0);
    v.rst = 1'b1;
    vecs.push_back(v);
    vecs.push_back(upd("updB_global", 20'h00020, 9'd1, 32'h0000_0020, 1'b0));
    vecs.push_back(upd("updC", 20'h00030, 9'd2, 32'h0003_00CF, 1'b0));
    vecs.push_back(fl("flush_asid1", 2'b10, 9'd1, 32'h0));
    vecs.push_back(lu("A_flushed", 9'd1, 32'h0001_0000, 1'b0, 1'b0, 32'h0));
    vecs.push_back(lu("B_survives", 9'd1, 32'h0002_0000, 1'b1, 1'b0, 32'h0000_0020));
    vecs.push_back(lu("C_survives", 9'd2, 32'h0003_0000, 1'b1, 1'b0, 32'h0003_00CF));
    vecs.push_back(lu("B_other_asid", 9'd5, 32'h0002_0000, 1'b1, 1'b0, 32'h0000_0020));
    vecs.push_back(fl("flush_vaddrB", 2'b01, 9'd1, 32'h0002_0000));
    vecs.push_back(lu("B_flushed", 9'd1, 32'h0002_0000, 1'b0, 1'b0, 32'h0));
    vecs.push_back(lu("C_after_vflush", 9'd2, 32'h0003_0000, 1'b1, 1'b0, 32'h0003_00CF));
    vecs.push_back(upd("updD_asid3", 20'h00040, 9'd3, 32'h0004_00CF, 1'b0));
    vecs.push_back(upd("updE_asid4", 20'h00040, 9'd4, 32'h0004_10CF, 1'b0));
    vecs.push_back(fl("flush_asid3_vaddr", 2'b11, 9'd3, 32'h0004_0000));
    vecs.push_back(lu("D_flushed", 9'd3, 32'h0004_0000, 1'b0, 1'b0, 32'h0));
    vecs.push_back(lu("E_survives", 9'd4, 32'h0004_0000, 1'b1, 1'b0, 32'h0004_10CF));

    // Same-cycle interactions.
    v = upd("flushall_with_upd7", 20'h00007, 9'd1, 32'h0000_70CF, 1'b0);
    v.fl = 1'b1;
    v.fl_mode = 2'b00;
    vecs.push_back(v);
    vecs.push_back(lu("upd7_dropped", 9'd1, 32'h0000_7000, 1'b0, 1'b0, 32'h0));
    vecs.push_back(lu("C_flushall", 9'd2, 32'h0003_0000, 1'b0, 1'b0, 32'h0));
    vecs.push_back(lu("E_flushall", 9'd4, 32'h0004_0000, 1'b0, 1'b0, 32'h0));
    v = upd("upd8_with_lookup", 20'h00008, 9'd1, 32'h0000_80CF, 1'b0);
    v.lu = 1'b1;
    v.lu_asid = 9'd1;
    v.lu_vaddr = 32'h0000_8000;
    vecs.push_back(v);
    vecs.push_back(lu("hit8_next", 9'd1, 32'h0000_8000, 1'b1, 1'b0, 32'h0000_80CF));
    v = lu("lookup_with_flush", 9'd1, 32'h0000_8000, 1'b0, 1'b0, 32'h0);
    v.fl = 1'b1;
    v.fl_mode = 2'b10;
    v.fl_asid = 9'd7;
    vecs.push_back(v);
    vecs.push_back(lu("hit8_after_flush", 9'd1, 32'h0000_8000, 1'b1, 1'b0, 32'h0000_80CF));
    vecs.push_back(upd("overwrite8", 20'h00008, 9'd1, 32'h0000_81CF, 1'b0));
    vecs.push_back(lu("hit8_overwritten", 9'd1, 32'h0000_8000, 1'b1, 1'b0, 32'h0000_81CF));

    idleInputs();
    rst_i = 1'b1;
    #12;
    rst_i = 1'b0;
    checkOutput("reset_state", 1'b0, 1'b0, 32'h0);
    @(posedge clk_i);
    #1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i].name, vecs[i].exp_hit, vecs[i].exp_4m, vecs[i].exp_content);
    end

    // Reset landing after a hit has been registered clears it asynchronously.
    applyStimulus(upd("upd9", 20'h00009, 9'd1, 32'h0000_90CF, 1'b0));
    applyStimulus(lu("hit9", 9'd1, 32'h0000_9000, 1'b1, 1'b0, 32'h0000_90CF));
    checkOutput("hit9_before_rst", 1'b1, 1'b0, 32'h0000_90CF);
    rst_i = 1'b1;
    #1;
    checkOutput("async_rst_clears", 1'b0, 1'b0, 32'h0);
    #1;
    rst_i = 1'b0;
    applyStimulus(lu("first_after_rst", 9'd1, 32'h0000_9000, 1'b0, 1'b0, 32'h0));
    checkOutput("first_after_rst", 1'b0, 1'b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
